shift_rotate_pipe: RTL and testbench

//  Parametrised, pipelined barrel shift/rotate unit. Five modes, one log2 stage per pipe register.

---
 rtl/shift_rotate_pipe.sv | 181 ++++++++++++++++++
 tb/tb_shift_rotate_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_pipe.sv
// Pipelined barrel shift/rotate unit: SLL, SRL, SRA, ROL, ROR and PASS.
// One log2 stage per pipe register; stage k shifts by 2^k when amt[k] is set.
// Valid/ready handshake on both sides with bubble-collapsing stalls.
// Optional feature: define SHIFT_ZERO_FLAG_EN to add a registered `zero` output.
module shift_rotate_pipe #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] src,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       op,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] res,
  output logic             carry
`ifdef SHIFT_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned LAST = AMT_W - 1;

  // Per-stage registers
  logic [AMT_W-1:0] vld_q, vld_d, load, adv;
  logic [WIDTH-1:0] data_q  [AMT_W];
  logic             carry_q [AMT_W];
  logic [2:0]       op_q    [AMT_W];
  logic [AMT_W-1:0] amt_q   [AMT_W];

  // Stage inputs and combinational stage results
  logic [WIDTH-1:0] st_data  [AMT_W];
  logic             st_carry [AMT_W];
  logic [2:0]       st_op    [AMT_W];
  logic [AMT_W-1:0] st_amt   [AMT_W];
  logic [WIDTH-1:0] nx_data  [AMT_W];
  logic             nx_carry [AMT_W];
  logic             full_dn;

  // One stage: shift by sh when en, otherwise pass data and carry through.
  function automatic logic [WIDTH:0] stage_fn(input logic [WIDTH-1:0] d,
                                              input logic [2:0]       o,
                                              input logic             en,
                                              input logic             c_in,
                                              input int unsigned      sh);
    logic [WIDTH-1:0]   r;
    logic               c;
    logic [2*WIDTH-1:0] w;
    r = d;
    c = c_in;
    w = '0;
    if (en) begin
      case (o)
        3'b000: begin
          r = d << sh;
          c = |(d & (WIDTH'(1) << (WIDTH - sh)));
        end
        3'b001: begin
          r = d >> sh;
          c = |(d & (WIDTH'(1) << (sh - 1)));
        end
        3'b010: begin
          r = $signed(d) >>> sh;
          c = |(d & (WIDTH'(1) << (sh - 1)));
        end
        3'b011: begin
          w = {d, d} << sh;
          r = w[2*WIDTH-1:WIDTH];
          c = r[0];
        end
        3'b100: begin
          w = {d, d} >> sh;
          r = w[WIDTH-1:0];
          c = r[WIDTH-1];
        end
        default: begin
          r = d;
          c = 1'b0;
        end
      endcase
    end
    return {c, r};
  endfunction

  // Route each stage's inputs: stage 0 from the ports, later stages from the previous register
  always_comb begin
    st_data[0]  = src;
    st_carry[0] = 1'b0;
    st_op[0]    = op;
    st_amt[0]   = amt;
    for (int k = 1; k < AMT_W; k++) begin
      st_data[k]  = data_q[k-1];
      st_carry[k] = carry_q[k-1];
      st_op[k]    = op_q[k-1];
      st_amt[k]   = amt_q[k-1];
    end
  end

  // Shift datapath for every stage
  always_comb begin
    for (int k = 0; k < AMT_W; k++) begin
      {nx_carry[k], nx_data[k]} = stage_fn(st_data[k], st_op[k],
                                           |(st_amt[k] & (AMT_W'(1) << k)),
                                           st_carry[k], 32'd1 << k);
    end
  end

  // Flow control: a stage advances if any downstream stage is empty or the output drains
  always_comb begin
    adv     = '0;
    load    = '0;
    vld_d   = '0;
    full_dn = 1'b1;
    for (int k = 0; k < AMT_W; k++) begin
      full_dn = 1'b1;
      for (int j = k + 1; j < AMT_W; j++) begin
        full_dn = full_dn & vld_q[j];
      end
      adv[k] = vld_q[k] & (~full_dn | out_rdy);
    end
    in_rdy  = ~flush & (~vld_q[0] | adv[0]);
    load[0] = in_vld & in_rdy;
    for (int k = 1; k < AMT_W; k++) begin
      load[k] = adv[k-1];
    end
    // flush wins over everything, including a draining output
    for (int k = 0; k < AMT_W; k++) begin
      vld_d[k] = ~flush & (load[k] | (vld_q[k] & ~adv[k]));
    end
  end

  // Pipe registers; payload only changes on load so stalled stages hold stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < AMT_W; k++) begin
        data_q[k]  <= '0;
        carry_q[k] <= 1'b0;
        op_q[k]    <= '0;
        amt_q[k]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < AMT_W; k++) begin
        if (load[k]) begin
          data_q[k]  <= nx_data[k];
          carry_q[k] <= nx_carry[k];
          op_q[k]    <= st_op[k];
          amt_q[k]   <= st_amt[k];
        end
      end
    end
  end

  assign out_vld = vld_q[LAST];
  assign res     = data_q[LAST];
  assign carry   = carry_q[LAST];

`ifdef SHIFT_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag registered alongside the last-stage data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (load[LAST]) begin
      zero_q <= (nx_data[LAST] == '0);
    end
  end

  assign zero = zero_q;
`else
  // No zero flag in this build.
`endif

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Self-checking bench for shift_rotate_pipe (WIDTH=16): directed vector table,
// backpressure, streaming against a bit-serial model, async reset and flush.
module tb_shift_rotate_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b1;
  logic [15:0] src = '0;
  logic [3:0]  amt = '0;
  logic [2:0]  op = '0;
  logic        in_rdy, out_vld, carry;
  logic [15:0] res;
`ifdef SHIFT_ZERO_FLAG_EN
  logic        zero;
`endif

  shift_rotate_pipe #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .src     (src),
    .amt     (amt),
    .op      (op),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .res     (res),
    .carry   (carry)
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    .zero    (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  amt;
    logic [15:0] src;
    logic [15:0] res;
    logic        carry;
  } vec_t;

  vec_t        vecs [16];
  int          total = 0;
  int          bad = 0;
  int          n_out = 0;
  logic [16:0] exp_q [$];
  logic        s_in_rdy, s_out_vld;
  logic [15:0] s_res;

  // Bit-serial reference: one single-bit step per unit of amt
  function automatic logic [16:0] golden(input logic [2:0] o, input logic [3:0] a,
                                         input logic [15:0] s);
    logic [15:0] d;
    logic        c;
    d = s;
    c = 1'b0;
    for (int i = 0; i < int'(a); i++) begin
      case (o)
        3'b000: begin c = d[15]; d = {d[14:0], 1'b0}; end
        3'b001: begin c = d[0];  d = {1'b0, d[15:1]}; end
        3'b010: begin c = d[0];  d = {d[15], d[15:1]}; end
        3'b011: begin c = d[15]; d = {d[14:0], d[15]}; end
        3'b100: begin c = d[0];  d = {d[0], d[15:1]}; end
        default: ;
      endcase
    end
    return {c, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One handshake cycle with scoreboard: sample at negedge, advance past posedge
  task automatic cycle(output logic took);
    logic [16:0] e;
    @(negedge clk);
    s_in_rdy  = in_rdy;
    s_out_vld = out_vld;
    s_res     = res;
    took      = in_vld && in_rdy;
    if (took) exp_q.push_back(golden(op, amt, src));
    if (out_vld && out_rdy) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(res), 32'hdead_0000);
      end else begin
        e = exp_q.pop_front();
        chk("sb_res", 32'(res), 32'(e[15:0]));
        chk("sb_carry", 32'(carry), 32'(e[16]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        took;
    int          n;
    int          idx;
    int          sent;
    int          emit_cyc [4];
    logic [15:0] bp [6];

    vecs[0]  = '{3'b000, 4'd1,  16'h8001, 16'h0002, 1'b1};
    vecs[1]  = '{3'b001, 4'd1,  16'h8001, 16'h4000, 1'b1};
    vecs[2]  = '{3'b010, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
    vecs[3]  = '{3'b010, 4'd15, 16'h7FFF, 16'h0000, 1'b1};
    vecs[4]  = '{3'b011, 4'd1,  16'h8001, 16'h0003, 1'b1};
    vecs[5]  = '{3'b100, 4'd4,  16'h0001, 16'h1000, 1'b0};
    vecs[6]  = '{3'b000, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
    vecs[7]  = '{3'b100, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
    vecs[8]  = '{3'b111, 4'd5,  16'h1234, 16'h1234, 1'b0};
    vecs[9]  = '{3'b000, 4'd15, 16'h0001, 16'h8000, 1'b0};
    vecs[10] = '{3'b001, 4'd15, 16'hC000, 16'h0001, 1'b1};
    vecs[11] = '{3'b011, 4'd4,  16'h1234, 16'h2341, 1'b1};
    vecs[12] = '{3'b100, 4'd8,  16'h1234, 16'h3412, 1'b0};
    vecs[13] = '{3'b010, 4'd4,  16'h8F08, 16'hF8F0, 1'b1};
    vecs[14] = '{3'b101, 4'd3,  16'hBEEF, 16'hBEEF, 1'b0};
    vecs[15] = '{3'b000, 4'd8,  16'h01FF, 16'hFF00, 1'b1};
    for (int i = 0; i < 6; i++) bp[i] = 16'(16'h0011 * (i + 1));

    // Reset state
    tick();
    tick();
    chk("reset_out_vld", 32'(out_vld), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);
    rst = 1'b0;
    tick();
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);

    // Directed table: one word at a time, check latency and result
    foreach (vecs[i]) begin
      in_vld = 1'b1;
      op     = vecs[i].op;
      amt    = vecs[i].amt;
      src    = vecs[i].src;
      @(negedge clk);
      chk($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'd1);
      tick();
      in_vld = 1'b0;
      n = 0;
      while (!out_vld && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
      chk($sformatf("vec%0d_res", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].carry));
      tick();
    end

    // Backpressure: out_rdy low, offer 6 words, only 4 fit
    exp_q.delete();
    n_out   = 0;
    out_rdy = 1'b0;
    op      = 3'b000;
    amt     = 4'd0;
    idx     = 0;
    for (int c = 0; c < 8; c++) begin
      in_vld = 1'b1;
      src    = bp[idx];
      cycle(took);
      if (took) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_in_rdy_low", 32'(s_in_rdy), 32'd0);
    chk("bp_out_vld", 32'(s_out_vld), 32'd1);
    chk("bp_res_held", 32'(s_res), 32'(bp[0]));
    cycle(took);
    chk("bp_res_stable", 32'(s_res), 32'(bp[0]));
    chk("bp_no_take", 32'(took), 32'd0);
    out_rdy = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_vld = (idx < 6);
      if (idx < 6) src = bp[idx];
      n = n_out;
      cycle(took);
      if (c == 0) chk("bp_full_drain_in_rdy", 32'(s_in_rdy), 32'd1);
      if (took) idx++;
      if (n_out > n && n_out <= 4) emit_cyc[n_out-1] = c;
    end
    in_vld = 1'b0;
    chk("bp_total_out", 32'(n_out), 32'd6);
    chk("bp_consecutive", 32'(emit_cyc[3] - emit_cyc[0]), 32'd3);

    // Streaming: back-to-back random words, random out_rdy
    exp_q.delete();
    n_out = 0;
    sent  = 0;
    op    = 3'($urandom_range(0, 7));
    amt   = 4'($urandom_range(0, 15));
    src   = 16'($urandom);
    for (int c = 0; c < 2000 && (sent < 100 || exp_q.size() > 0); c++) begin
      in_vld  = (sent < 100);
      out_rdy = 1'($urandom_range(0, 1));
      cycle(took);
      if (took) begin
        sent++;
        op  = 3'($urandom_range(0, 7));
        amt = 4'($urandom_range(0, 15));
        src = 16'($urandom);
      end
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    chk("stream_count", 32'(n_out), 32'd100);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
    tick();

    // Async reset with 3 words in flight
    out_rdy = 1'b0;
    op      = 3'b000;
    amt     = 4'd0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      src    = 16'(16'h1111 * (i + 1));
      tick();
    end
    in_vld = 1'b0;
    tick();
    tick();
    chk("rst_pre_out_vld", 32'(out_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    tick();
    rst     = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_vld) n++;
    end
    chk("rst_nothing_emerges", 32'(n), 32'd0);

    // Flush with 2 words in flight
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1;
      src    = 16'(16'h2222 * (i + 1));
      tick();
    end
    flush = 1'b1;
    src   = 16'h7777;
    @(negedge clk);
    chk("flush_in_rdy", 32'(in_rdy), 32'd0);
    tick();
    flush  = 1'b0;
    in_vld = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_vld) n++;
      tick();
    end
    chk("flush_nothing_emerges", 32'(n), 32'd0);

`ifdef SHIFT_ZERO_FLAG_EN
    in_vld = 1'b1;
    op     = 3'b000;
    amt    = 4'd1;
    src    = 16'h8000;
    tick();
    in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 10) begin
      tick();
      n++;
    end
    chk("zero_flag", 32'(zero), 32'd1);
    chk("zero_res", 32'(res), 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
